// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one registered 8-bit FP adder between N_REQ
// requesters. Tracks requester IDs through the adder latency and returns
// tagged results through a credit-protected response FIFO.
module fp_add_arbiter #(
    parameter int N_REQ     = 4,
    parameter int ADD_LAT   = 1,
    parameter int RSP_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           ena,
    input  logic [N_REQ-1:0]               req_valid,
    input  logic [8*N_REQ-1:0]             req_a,
    input  logic [8*N_REQ-1:0]             req_b,
    output logic [N_REQ-1:0]               req_ready,
    output logic [7:0]                     add_a,
    output logic [7:0]                     add_b,
    output logic                           add_en,
    input  logic [7:0]                     add_res,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [7:0]                     rsp_data,
    output logic [$clog2(N_REQ)-1:0]       rsp_id,
    output logic [1:0]                     inflight,
    output logic [$clog2(RSP_DEPTH):0]     rsp_count
);

    localparam int IDW = $clog2(N_REQ);
    localparam int AW  = $clog2(RSP_DEPTH);
    localparam int CW  = AW + 1;

    logic [IDW-1:0]     rr_ptr;
    logic [7:0]         hold_a, hold_b;
    logic [ADD_LAT-1:0] tag_vld;
    logic [IDW-1:0]     tag_id [ADD_LAT];
    logic [7:0]         data_mem [RSP_DEPTH];
    logic [IDW-1:0]     id_mem [RSP_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      count;

    logic               grant_found;
    logic [IDW-1:0]     grant_idx;
    logic [7:0]         sel_a, sel_b;
    logic [1:0]         inflight_cnt;
    logic [CW:0]        credit_used;
    logic               issue_ok;
    logic               push, pop;

    // Round-robin search from rr_ptr with wrap-around; first valid request wins.
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        sel_a       = '0;
        sel_b       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int j;
            j = (int'(rr_ptr) + k) % N_REQ;
            if (!grant_found && req_valid[j]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(j);
                sel_a       = req_a[8*j +: 8];
                sel_b       = req_b[8*j +: 8];
            end
        end
    end

    // Count valid tag stages and decide whether a new issue fits the FIFO credit.
    always_comb begin
        inflight_cnt = '0;
        for (int s = 0; s < ADD_LAT; s++) begin
            inflight_cnt = inflight_cnt + 2'(tag_vld[s]);
        end
        credit_used = {{(CW-1){1'b0}}, inflight_cnt} + {1'b0, count};
        // rst_n gates issue so the grant outputs fall to zero the moment reset asserts.
        issue_ok    = rst_n && ena && (credit_used < (CW+1)'(RSP_DEPTH));
    end

    // Grant, adder drive and FIFO head outputs.
    always_comb begin
        add_en    = issue_ok && grant_found;
        req_ready = '0;
        if (add_en) begin
            req_ready[grant_idx] = 1'b1;
        end
        add_a     = add_en ? sel_a : hold_a;
        add_b     = add_en ? sel_b : hold_b;
        push      = tag_vld[ADD_LAT-1];
        rsp_valid = (count != '0);
        pop       = rsp_valid && rsp_ready;
        rsp_data  = rsp_valid ? data_mem[rd_ptr] : '0;
        rsp_id    = rsp_valid ? id_mem[rd_ptr] : '0;
        inflight  = inflight_cnt;
        rsp_count = count;
    end

    // RR pointer, held operands and the {valid,id} tag shift register.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= '0;
            hold_a  <= '0;
            hold_b  <= '0;
            tag_vld <= '0;
            for (int s = 0; s < ADD_LAT; s++) begin
                tag_id[s] <= '0;
            end
        end else begin
            if (add_en) begin
                rr_ptr <= (grant_idx == IDW'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
                hold_a <= sel_a;
                hold_b <= sel_b;
            end
            tag_vld[0] <= add_en;
            tag_id[0]  <= grant_idx;
            for (int s = 1; s < ADD_LAT; s++) begin
                tag_vld[s] <= tag_vld[s-1];
                tag_id[s]  <= tag_id[s-1];
            end
        end
    end

    // Response FIFO storage; contents are only visible while count says they are valid.
    // NOTE: the storage array has no reset; pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= add_res;
            id_mem[wr_ptr]   <= tag_id[ADD_LAT-1];
        end
    end

    // Response FIFO pointers and occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter: a behavioural FP8 adder with one cycle of
// latency feeds add_res; a scoreboard queue holds expected {result,id} pairs.
module tb_fp_add_arbiter;

    localparam int N_REQ     = 4;
    localparam int ADD_LAT   = 1;
    localparam int RSP_DEPTH = 4;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] id;
    } rsp_t;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic [3:0]  req_valid;
    logic [31:0] req_a, req_b;
    logic [3:0]  req_ready;
    logic [7:0]  add_a, add_b;
    logic        add_en;
    logic [7:0]  add_res;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_id;
    logic [1:0]  inflight;
    logic [2:0]  rsp_count;

    logic [7:0]  op_a [4];
    logic [7:0]  op_b [4];
    logic [7:0]  res_pipe [ADD_LAT];
    rsp_t        sb [$];
    int          total = 0;
    int          bad   = 0;

    fp_add_arbiter #(.N_REQ(N_REQ), .ADD_LAT(ADD_LAT), .RSP_DEPTH(RSP_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .add_a(add_a), .add_b(add_b), .add_en(add_en), .add_res(add_res),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .inflight(inflight), .rsp_count(rsp_count)
    );

    assign req_a   = {op_a[3], op_a[2], op_a[1], op_a[0]};
    assign req_b   = {op_b[3], op_b[2], op_b[1], op_b[0]};
    assign add_res = res_pipe[ADD_LAT-1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference FP8 add: bias 7, subnormals at exponent 0, truncation, clamp on overflow.
    function automatic logic [7:0] fp_add(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] x, y;
        int ex, ey, mx, my, m, e;
        if (a[6:0] >= b[6:0]) begin x = a; y = b; end
        else                  begin x = b; y = a; end
        ex = (x[6:3] == 4'd0) ? 1 : int'(x[6:3]);
        ey = (y[6:3] == 4'd0) ? 1 : int'(y[6:3]);
        mx = ((x[6:3] != 4'd0) ? 8 : 0) + int'(x[2:0]);
        my = ((y[6:3] != 4'd0) ? 8 : 0) + int'(y[2:0]);
        my = my >> (ex - ey);
        m  = (x[7] == y[7]) ? mx + my : mx - my;
        e  = ex;
        if (m == 0) return 8'h00;
        if (m >= 16) begin m = m >> 1; e = e + 1; end
        while (m < 8 && e > 1) begin m = m << 1; e = e - 1; end
        if (m < 8) e = 0;
        if (e >= 15) return {x[7], 7'h78};
        return {x[7], 4'(e), 3'(m)};
    endfunction

    // Behavioural adder core with ADD_LAT register stages.
    always @(posedge clk) begin
        if (add_en) res_pipe[0] <= fp_add(add_a, add_b);
        for (int s = 1; s < ADD_LAT; s++) res_pipe[s] <= res_pipe[s-1];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted response must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL rsp_unexpected observed id=%0h data=%0h expected none", rsp_id, rsp_data);
            end
            if (sb.size() != 0) begin
                rsp_t e;
                e = sb.pop_front();
                check("rsp_data", rsp_data, e.data);
                check("rsp_id", rsp_id, e.id);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_grant(input int g, input int cnt = -1);
        rsp_t e;
        @(negedge clk);
        check("req_ready", req_ready, 32'(4'b0001 << g));
        check("add_en", add_en, 1);
        check("add_a", add_a, op_a[g]);
        check("add_b", add_b, op_b[g]);
        if (cnt >= 0) check("rsp_count_steady", rsp_count, cnt);
        e.data = fp_add(op_a[g], op_b[g]);
        e.id   = 2'(g);
        sb.push_back(e);
        tick();
    endtask

    task automatic exp_idle();
        @(negedge clk);
        check("idle_req_ready", req_ready, 0);
        check("idle_add_en", add_en, 0);
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_add_en"}, add_en, 0);
        check({tag, "_add_a"}, add_a, 0);
        check({tag, "_add_b"}, add_b, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_data"}, rsp_data, 0);
        check({tag, "_rsp_id"}, rsp_id, 0);
        check({tag, "_inflight"}, inflight, 0);
        check({tag, "_rsp_count"}, rsp_count, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ena = 1'b0; req_valid = '0; rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin op_a[i] = '0; op_b[i] = '0; end
        op_a[0] = 8'h21; op_b[0] = 8'h19;
        op_a[1] = 8'h3C; op_b[1] = 8'hB2;
        op_a[2] = 8'hA5; op_b[2] = 8'hA5;
        op_a[3] = 8'h70; op_b[3] = 8'h6F;
        #3;
        check_all_zero("reset");
        tick();
        rst_n = 1'b1;

        // 1: single request, latency to rsp_valid
        ena = 1'b1; req_valid = 4'b0001;
        exp_grant(0);
        req_valid = '0;
        @(negedge clk);
        check("t1_inflight", inflight, 1);
        check("t1_rsp_valid_early", rsp_valid, 0);
        tick();
        @(negedge clk);
        check("t1_rsp_valid", rsp_valid, 1);
        check("t1_rsp_count", rsp_count, 1);
        check("t1_inflight_done", inflight, 0);
        check("t1_rsp_data", rsp_data, fp_add(8'h21, 8'h19));
        check("t1_rsp_id", rsp_id, 0);
        tick();
        rsp_ready = 1'b1;
        tick();
        @(negedge clk);
        check("t1_rsp_count_drained", rsp_count, 0);
        tick();

        // 2: round robin from pointer 0, one response per cycle
        do_reset();
        req_valid = 4'hF;
        exp_grant(0); exp_grant(1); exp_grant(2); exp_grant(3); exp_grant(0); exp_grant(1);
        req_valid = '0;
        repeat (4) exp_idle();
        check("t2_sb_empty", sb.size(), 0);
        check("t2_rsp_count", rsp_count, 0);

        // 3: backpressure, credit stops at RSP_DEPTH, one pop yields one grant
        rsp_ready = 1'b0; req_valid = 4'hF;
        exp_grant(2); exp_grant(3); exp_grant(0); exp_grant(1);
        exp_idle();
        @(negedge clk);
        check("t3_full_req_ready", req_ready, 0);
        check("t3_full_count", rsp_count, 4);
        tick();
        rsp_ready = 1'b1;
        exp_idle();
        rsp_ready = 1'b0;
        exp_grant(2);
        exp_idle();
        exp_idle();
        @(negedge clk);
        check("t3_refill_count", rsp_count, 4);
        tick();

        // 4: steady push/pop at occupancy 2
        req_valid = '0; rsp_ready = 1'b1;
        repeat (5) exp_idle();
        check("t4_drained", sb.size(), 0);
        rsp_ready = 1'b0; req_valid = 4'hF;
        exp_grant(3); exp_grant(0); exp_grant(1);
        rsp_ready = 1'b1;
        exp_grant(2, 2); exp_grant(3, 2); exp_grant(0, 2); exp_grant(1, 2);
        req_valid = '0;
        repeat (4) exp_idle();
        check("t4_sb_empty", sb.size(), 0);
        check("t4_rsp_count", rsp_count, 0);

        // 5: ena drop blocks grants, in-flight work still completes
        rsp_ready = 1'b0; req_valid = 4'hF;
        exp_grant(2); exp_grant(3);
        ena = 1'b0;
        @(negedge clk);
        check("t5_req_ready", req_ready, 0);
        check("t5_add_en", add_en, 0);
        check("t5_hold_a", add_a, op_a[3]);
        check("t5_hold_b", add_b, op_b[3]);
        check("t5_inflight", inflight, 1);
        tick();
        @(negedge clk);
        check("t5_inflight_zero", inflight, 0);
        check("t5_count", rsp_count, 2);
        tick();
        rsp_ready = 1'b1;
        repeat (3) exp_idle();
        check("t5_sb_empty", sb.size(), 0);

        // 6: async reset mid-stream
        ena = 1'b1; rsp_ready = 1'b0; req_valid = 4'hF;
        exp_grant(0); exp_grant(1); exp_grant(2); exp_grant(3);
        #2;
        check("t6_pre_inflight", inflight, 1);
        check("t6_pre_count", rsp_count, 3);
        rst_n = 1'b0;
        #1;
        check_all_zero("t6_async");
        sb.delete();
        tick();
        rst_n = 1'b1;
        req_valid = '0; rsp_ready = 1'b1;
        repeat (3) exp_idle();
        @(negedge clk);
        check("t6_no_stale", rsp_valid, 0);
        tick();
        req_valid = 4'hF;
        exp_grant(0);
        req_valid = '0;
        repeat (3) exp_idle();
        check("t6_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
